// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that lends one shared up-counter to
// N requesters in turn. The granted requester's terminal count is latched at
// grant time; the block pulses done when the counter reaches it, or quietly
// releases the counter if the requester withdraws first. A one-cycle CLEAR
// state with the enable low lets the counter reset before the next grant.
module counter_sched #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_tc,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic           cnt_enable,
  input  logic [W-1:0]   cnt_value
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [W-1:0]  r_tc, w_tc_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt;
  logic [N-1:0]  r_done, w_done_nxt;
  logic          r_en, w_en_nxt;
  logic [IW-1:0] w_winner;
  logic          w_found;

  // Requester index k positions after ptr, wrapping modulo N.
  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] ptr, input int k);
    int j;
    j = int'(ptr) + k;
    if (j >= N) j = j - N;
    return IW'(j);
  endfunction

  // Round-robin pick: first active request after the last winner.
  always_comb begin
    w_winner = r_rr_ptr;
    w_found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req[rr_next(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_next(r_rr_ptr, k);
      end
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_idx_nxt    = r_idx;
    w_tc_nxt     = r_tc;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_en_nxt     = r_en;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        w_en_nxt    = 1'b0;
        if (w_found) begin
          w_idx_nxt    = w_winner;
          w_tc_nxt     = req_tc[w_winner*W +: W];
          w_rr_ptr_nxt = w_winner;
          w_grant_nxt  = N'(1) << w_winner;
          w_en_nxt     = 1'b1;
          w_state_nxt  = RUN;
        end
      end
      RUN: begin
        // Completion takes priority over a simultaneous withdrawal.
        if (cnt_value == r_tc) begin
          w_done_nxt[r_idx] = 1'b1;
          w_grant_nxt       = '0;
          w_en_nxt          = 1'b0;
          w_state_nxt       = CLEAR;
        end else if (!req[r_idx]) begin
          w_grant_nxt = '0;
          w_en_nxt    = 1'b0;
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        w_grant_nxt = '0;
        w_en_nxt    = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_en_nxt    = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, latched grant context and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_rr_ptr <= IW'(N - 1);
      r_idx    <= '0;
      r_tc     <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_en     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_idx    <= w_idx_nxt;
      r_tc     <= w_tc_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_en     <= w_en_nxt;
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign cnt_enable = r_en;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: a time-arithmetic reference model predicts grant,
// done and release events into a queue; a negedge monitor pops and compares
// them against what the DUT shows. Directed scenarios precede random traffic.
module tb_counter_sched;
  localparam int N = 4;
  localparam int W = 8;

  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_END   = 2;

  logic           clock = 1'b0;
  logic           resetn;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_tc;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic           cnt_enable;
  logic [W-1:0]   cnt_value = '0;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } ev_t;
  ev_t expq[$];

  counter_sched #(.N(N), .W(W)) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_tc(req_tc),
    .grant(grant), .done(done), .busy(busy), .cnt_enable(cnt_enable),
    .cnt_value(cnt_value)
  );

  always #5 clock = ~clock;

  // Shared counter: counts while enabled, clears whenever enable is low.
  always @(posedge clock) begin
    if (!cnt_enable) cnt_value <= '0;
    else             cnt_value <= cnt_value + 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on edge numbers: a grant at edge g completes at edge g+tc+1 unless
  // the request is seen low earlier; arbitration resumes two edges after release.
  int cyc = 0;
  bit m_active = 0;
  int m_idx, m_g, m_tc;
  int m_rr = N - 1;
  int m_next_arb = 0;
  bit exp_busy = 0, exp_en = 0;

  always @(posedge clock) begin
    if (!resetn) begin
      m_active   = 0;
      m_rr       = N - 1;
      m_next_arb = cyc + 1;
      exp_busy   = 0;
      exp_en     = 0;
    end else begin
      bit ended;
      ended = 0;
      if (m_active) begin
        if (cyc == m_g + m_tc + 1) begin
          expq.push_back('{EV_DONE, m_idx, cyc + 1});
          expq.push_back('{EV_END, m_idx, cyc + 1});
          ended = 1;
        end else if (!req[m_idx]) begin
          expq.push_back('{EV_END, m_idx, cyc + 1});
          ended = 1;
        end
        if (ended) begin
          m_active   = 0;
          m_next_arb = cyc + 2;
        end
      end else if (cyc >= m_next_arb && req != '0) begin
        int win;
        win = -1;
        for (int k = 1; k <= N; k++)
          if (win < 0 && req[(m_rr + k) % N]) win = (m_rr + k) % N;
        m_rr     = win;
        m_idx    = win;
        m_tc     = int'(req_tc[win*W +: W]);
        m_g      = cyc;
        m_active = 1;
        expq.push_back('{EV_GRANT, win, cyc + 1});
      end
      exp_en   = m_active;
      exp_busy = m_active || ended;
    end
    cyc++;
  end

  // ---------------- monitor ----------------
  logic [N-1:0] prev_grant = '0;

  task automatic take(input int kind, input int idx, input string name);
    ev_t e;
    if (expq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s unexpected: got idx %0d at cycle %0d, expected no event", name, idx, cyc);
    end else begin
      e = expq.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk({name, "_idx"},  idx,  e.idx);
      chk({name, "_cycle"}, cyc, e.cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clock) begin
    if (resetn) begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("cnt_enable", int'(cnt_enable), int'(exp_en));
      chk("onehot", int'($countones(grant) <= 1 && $countones(done) <= 1), 1);
      if (done != '0)                      take(EV_DONE,  onehot_idx(done), "done");
      if (grant == '0 && prev_grant != '0) take(EV_END,   onehot_idx(prev_grant), "release");
      if (grant != '0 && prev_grant == '0) take(EV_GRANT, onehot_idx(grant), "grant");
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
        ev_t e;
        e = expq.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_event: got nothing, expected kind %0d idx %0d at cycle %0d",
                 e.kind, e.idx, e.cyc);
      end
    end
    prev_grant = grant;
  end

  // ---------------- stimulus ----------------
  task automatic set_tc(input int i, input int v);
    req_tc[i*W +: W] = W'(v);
  endtask

  task automatic wait_done(input int i, input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clock);
      if (done[i]) break;
    end
    chk("done_seen", int'(done[i]), 1);
  endtask

  task automatic wait_grant(input int i, input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clock);
      if (grant[i]) break;
    end
    chk("grant_seen", int'(grant[i]), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  int abort_after[N];
  int gcnt[N];

  initial begin
    resetn = 1'b0;
    req    = '0;
    req_tc = '0;
    idle(3);
    chk("reset_grant", int'(grant), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt_enable", int'(cnt_enable), 0);
    resetn = 1'b1;
    idle(2);

    // single request, tc=5
    set_tc(0, 5);
    req = 4'b0001;
    wait_done(0, 20);
    req = '0;
    idle(4);

    // contention, all tc=2: five grants in round-robin order
    for (int i = 0; i < N; i++) set_tc(i, 2);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int seen;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clock);
        if (done != '0) seen = 1;
      end
      chk("contention_done_seen", seen, 1);
    end
    req = '0;
    idle(4);

    // tc=0
    set_tc(2, 0);
    req = 4'b0100;
    wait_done(2, 10);
    req = '0;
    idle(4);

    // abort three cycles into RUN
    set_tc(1, 20);
    req = 4'b0010;
    wait_grant(1, 10);
    idle(3);
    req = '0;
    idle(30);

    // asynchronous reset in the middle of a long RUN
    set_tc(0, 100);
    req = 4'b0001;
    wait_grant(0, 10);
    idle(10);
    #2 resetn = 1'b0;
    #1;
    chk("areset_grant", int'(grant), 0);
    chk("areset_done", int'(done), 0);
    chk("areset_busy", int'(busy), 0);
    chk("areset_cnt_enable", int'(cnt_enable), 0);
    req = '0;
    idle(2);
    resetn = 1'b1;
    set_tc(1, 3);
    set_tc(3, 4);
    req = 4'b1010;
    wait_grant(1, 5);
    wait_done(1, 20);
    req = 4'b1000;
    wait_done(3, 20);
    req = '0;
    idle(4);

    // maximum terminal count
    set_tc(3, 255);
    req = 4'b1000;
    wait_done(3, 300);
    req = '0;
    idle(4);

    // random traffic with withdrawals and terminal-count changes mid-run
    for (int i = 0; i < N; i++) begin
      abort_after[i] = -1;
      gcnt[i] = 0;
    end
    repeat (2000) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (grant[i]) gcnt[i]++;
        if (req[i]) begin
          if (done[i]) begin
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            gcnt[i] = 0;
          end else if (grant[i] && abort_after[i] >= 0 && gcnt[i] >= abort_after[i]) begin
            req[i] = 1'b0;
            gcnt[i] = 0;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          set_tc(i, $urandom_range(0, 12));
          abort_after[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
          gcnt[i] = 0;
          req[i] = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) set_tc(i, $urandom_range(0, 12));
      end
    end
    req = '0;
    idle(40);
    chk("queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
